pipe_stage_chain: RTL

- Parametrised pipeline-latch chain replacing the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries a DATA_W-bit payload through STAGES registered stages, each with its own valid bit.
- Per-stage stall with automatic bubble insertion, per-stage flush, output backpressure, and saturating stall/bubble/flush counters.
- Sits between datapath stages; the hazard/branch logic drives stall_in and flush_in.

---
 rtl/pipe_stage_chain.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised chain of pipeline latches.
// Each stage carries a DATA_W-bit payload plus its own valid bit. Stages can
// be stalled (freezing every younger stage behind them) or flushed (killing
// the stage and every younger stage). Output backpressure behaves like a
// stall of the oldest stage. Three saturating counters record stall cycles,
// bubble-insertion cycles and flush cycles for performance monitoring.

module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic [STAGES-1:0]          stall_in,
    input  logic [STAGES-1:0]          flush_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_fire,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*DATA_W-1:0]   stage_data,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]              bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]              flush_cnt_q, flush_cnt_d;

    logic [STAGES-1:0]             hold;
    logic [STAGES-1:0]             kill;
    logic                          hold_acc;
    logic                          kill_acc;
    logic                          bubble_any;

    // Hold ripples from the oldest stage toward the youngest, as does kill,
    // so a stall or flush at stage i always covers every younger stage.
    always_comb begin
        hold     = '0;
        kill     = '0;
        hold_acc = stall_in[STAGES-1] | (valid_q[STAGES-1] & ~out_ready);
        kill_acc = flush_in[STAGES-1];
        hold[STAGES-1] = hold_acc;
        kill[STAGES-1] = kill_acc;
        for (int i = STAGES-2; i >= 0; i--) begin
            hold_acc = hold_acc | stall_in[i];
            kill_acc = kill_acc | flush_in[i];
            hold[i]  = hold_acc;
            kill[i]  = kill_acc;
        end
    end

    // Next state of every stage: kill beats hold, hold beats advance; a stage
    // that advances while its source is held receives a bubble.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        bubble_any = 1'b0;

        if (kill[0]) begin
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = in_data;
            end
        end

        for (int i = 1; i < STAGES; i++) begin
            if (kill[i]) begin
                valid_d[i] = 1'b0;
            end else if (!hold[i]) begin
                valid_d[i] = valid_q[i-1] & ~hold[i-1];
                if (valid_q[i-1] && !hold[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
                if (valid_q[i-1] && hold[i-1]) begin
                    bubble_any = 1'b1;
                end
            end
        end
    end

    // Saturating event counters: each one sticks at all-ones once reached.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if ((|stall_in) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (bubble_any && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
        if ((|flush_in) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State registers; reset wipes valid bits, payloads and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            data_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign in_ready    = ~hold[0] & ~(|flush_in);
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign out_fire    = valid_q[STAGES-1] & out_ready & ~stall_in[STAGES-1] & ~flush_in[STAGES-1];
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
